// File: rtl/key_event_unit.sv
// key_event_unit: debounced multi-key input stage with press/release/long/repeat
// pulses and a small valid/ready event queue for downstream consumers.
module key_event_unit #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int FIFO_DEPTH      = 4,
    localparam int KEY_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic [1:0]          evt_type,
    output logic                evt_overflow
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] TYPE_PRESS   = 2'b00;
    localparam logic [1:0] TYPE_RELEASE = 2'b01;
    localparam logic [1:0] TYPE_LONG    = 2'b10;
    localparam logic [1:0] TYPE_REPEAT  = 2'b11;

    // Raw level that means "not pressed"; the synchroniser resets to it.
    localparam logic [NUM_KEYS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : '0;

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] key_now;
    logic [NUM_KEYS-1:0] db_fire;
    logic [DB_W-1:0]     db_cnt   [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_cnt [NUM_KEYS];
    logic [REP_W-1:0]    rep_cnt  [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_evt, rep_evt;

    logic [NUM_KEYS-1:0] pend_press, pend_rel, pend_long, pend_rep;
    logic [NUM_KEYS-1:0] gnt_press, gnt_rel, gnt_long, gnt_rep;
    logic                arb_valid;
    logic [KEY_W-1:0]    arb_key;
    logic [1:0]          arb_type;
    logic                dropped;

    logic [KEY_W+1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic                fifo_full;
    logic                pop;
    logic [KEY_W+1:0]    head;

    // Two-flop synchroniser per key; reset loads the idle raw level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign key_now = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // A channel accepts a change on the edge its mismatch count would reach the limit.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            db_fire[k] = (key_now[k] != key_level[k]) &&
                         (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    // Debounce counters, accepted level and press/release pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                press_pulse[k]   <= 1'b0;
                release_pulse[k] <= 1'b0;
                if (db_fire[k]) begin
                    db_cnt[k]        <= '0;
                    key_level[k]     <= key_now[k];
                    press_pulse[k]   <= key_now[k];
                    release_pulse[k] <= ~key_now[k];
                end else if (key_now[k] != key_level[k]) begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // Hold counter saturates at LONG_CYCLES; the repeat counter then takes over.
    // A release edge wins over a long/repeat that would land on the same edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            long_evt <= '0;
            rep_evt  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                hold_cnt[k] <= '0;
                rep_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                long_evt[k] <= 1'b0;
                rep_evt[k]  <= 1'b0;
                if (db_fire[k]) begin
                    hold_cnt[k] <= '0;
                    rep_cnt[k]  <= '0;
                end else if (key_level[k]) begin
                    if (hold_cnt[k] != HOLD_W'(LONG_CYCLES)) begin
                        hold_cnt[k] <= hold_cnt[k] + 1'b1;
                        long_evt[k] <= (hold_cnt[k] == HOLD_W'(LONG_CYCLES - 1));
                    end else if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt[k] == REP_W'(REPEAT_CYCLES - 1)) begin
                            rep_cnt[k] <= '0;
                            rep_evt[k] <= 1'b1;
                        end else begin
                            rep_cnt[k] <= rep_cnt[k] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign long_pulse = long_evt | rep_evt;

    // Pick one pending event: lowest channel, then press, long, repeat, release.
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        gnt_press = '0;
        gnt_rel   = '0;
        gnt_long  = '0;
        gnt_rep   = '0;
        arb_valid = 1'b0;
        arb_key   = '0;
        arb_type  = TYPE_PRESS;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (!arb_valid && (pend_press[k] | pend_long[k] | pend_rep[k] | pend_rel[k])) begin
                    // NOTE: blocking '=' here so later iterations see arb_valid already set; clocked blocks use '<=' only.
                    arb_valid = 1'b1;
                    arb_key   = KEY_W'(k);
                    if (pend_press[k]) begin
                        gnt_press[k] = 1'b1;
                        arb_type     = TYPE_PRESS;
                    end else if (pend_long[k]) begin
                        gnt_long[k] = 1'b1;
                        arb_type    = TYPE_LONG;
                    end else if (pend_rep[k]) begin
                        gnt_rep[k] = 1'b1;
                        arb_type   = TYPE_REPEAT;
                    end else begin
                        gnt_rel[k] = 1'b1;
                        arb_type   = TYPE_RELEASE;
                    end
                end
            end
        end
    end

    // A pulse arriving while its bit is still pending (and not granted now) is lost.
    assign dropped = |((press_pulse   & pend_press & ~gnt_press) |
                       (release_pulse & pend_rel   & ~gnt_rel)   |
                       (long_evt      & pend_long  & ~gnt_long)  |
                       (rep_evt       & pend_rep   & ~gnt_rep));

    // Pending bits per channel and type, plus the sticky overflow flag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_press   <= '0;
            pend_rel     <= '0;
            pend_long    <= '0;
            pend_rep     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~gnt_press) | press_pulse;
            pend_rel   <= (pend_rel   & ~gnt_rel)   | release_pulse;
            pend_long  <= (pend_long  & ~gnt_long)  | long_evt;
            pend_rep   <= (pend_rep   & ~gnt_rep)   | rep_evt;
            if (dropped) evt_overflow <= 1'b1;
        end
    end

    // Full is judged before any pop this cycle, so a pop never frees a slot early.
    assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid & evt_ready;

    // Queue pointers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (arb_valid) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Queue storage.
    // NOTE: storage is not reset; the pointers define which entries are meaningful.
    always_ff @(posedge sys_clk) begin
        if (arb_valid) fifo_mem[wr_ptr[PTR_W-1:0]] <= {arb_key, arb_type};
    end

    assign head     = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign evt_key  = evt_valid ? head[KEY_W+1:2] : '0;
    assign evt_type = evt_valid ? head[1:0]       : 2'b00;

endmodule

// File: tb/tb_key_event_unit.sv
// tb_key_event_unit: table-driven and hand-sequenced checks of key_event_unit
// with a scoreboard queue of expected queue events.
module tb_key_event_unit;

    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_REL   = 2'b01;
    localparam logic [1:0] T_LONG  = 2'b10;
    localparam logic [1:0] T_REP   = 2'b11;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [2:0] key_raw;
    logic [2:0] key_level, press_pulse, release_pulse, long_pulse;
    logic       evt_valid, evt_ready;
    logic [1:0] evt_key, evt_type;
    logic       evt_overflow;

    key_event_unit dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_raw      (key_raw),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_key      (evt_key),
        .evt_type     (evt_type),
        .evt_overflow (evt_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0] key;
        logic [1:0] typ;
    } evt_t;

    typedef struct {
        int key;
        int hold;
        int n_long;
    } vec_t;

    evt_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt_press[3] = '{0, 0, 0};
    int   cnt_rel[3]   = '{0, 0, 0};
    int   cnt_long[3]  = '{0, 0, 0};
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input int k, input logic [1:0] t);
        evt_t e;
        e.key = 2'(k);
        e.typ = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Watchdog: the run must never hang.
        fork
            begin
                #500000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Scoreboard monitor and pulse counters, sampled on the falling edge.
        fork
            forever begin
                @(negedge sys_clk);
                if (!sys_rst) begin
                    for (int k = 0; k < 3; k++) begin
                        if (press_pulse[k])   cnt_press[k]++;
                        if (release_pulse[k]) cnt_rel[k]++;
                        if (long_pulse[k])    cnt_long[k]++;
                    end
                    if (evt_valid && evt_ready) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_evt: got key %0d type %0b, wanted none", evt_key, evt_type);
                        end else begin
                            evt_t e;
                            e = exp_q.pop_front();
                            check("evt_key", 32'(evt_key), 32'(e.key));
                            check("evt_type", 32'(evt_type), 32'(e.typ));
                        end
                    end
                end
            end
        join_none

        vecs[0] = '{key: 0, hold: 20,  n_long: 0};
        vecs[1] = '{key: 1, hold: 120, n_long: 4};
        vecs[2] = '{key: 2, hold: 63,  n_long: 0};
        vecs[3] = '{key: 2, hold: 65,  n_long: 1};
        vecs[4] = '{key: 0, hold: 79,  n_long: 1};
        vecs[5] = '{key: 1, hold: 81,  n_long: 2};

        // Reset with keys idle.
        sys_rst   = 1'b1;
        key_raw   = 3'b111;
        evt_ready = 1'b1;
        tick();
        tick();
        check("rst_level", 32'(key_level), 0);
        check("rst_press", 32'(press_pulse), 0);
        check("rst_release", 32'(release_pulse), 0);
        check("rst_long", 32'(long_pulse), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_key", 32'(evt_key), 0);
        check("rst_type", 32'(evt_type), 0);
        check("rst_overflow", 32'(evt_overflow), 0);
        sys_rst = 1'b0;
        tick();

        // Bounce on key 0 shorter than the debounce window.
        for (int i = 0; i < 18; i++) begin
            key_raw[0] = (i < 10) ? 1'(i % 2) : 1'b1;
            tick();
            check("bounce_level", 32'(key_level), 0);
            check("bounce_press", 32'(press_pulse), 0);
            check("bounce_valid", 32'(evt_valid), 0);
        end

        // Clean press on key 0: exact latency and a single-cycle press pulse.
        push(0, T_PRESS);
        push(0, T_REL);
        key_raw[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("latency_level", 32'(key_level[0]), (i == 6) ? 1 : 0);
            check("latency_press", 32'(press_pulse[0]), (i == 6) ? 1 : 0);
        end
        tick();
        check("press_one_cycle", 32'(press_pulse), 0);
        repeat (13) tick();
        key_raw[0] = 1'b1;
        repeat (12) tick();
        check("clean_released", 32'(key_level), 0);
        wait_drain();

        // Table of holds around the long and repeat boundaries.
        for (int v = 0; v < 6; v++) begin
            int p0, r0, l0;
            p0 = cnt_press[vecs[v].key];
            r0 = cnt_rel[vecs[v].key];
            l0 = cnt_long[vecs[v].key];
            push(vecs[v].key, T_PRESS);
            for (int j = 0; j < vecs[v].n_long; j++) push(vecs[v].key, (j == 0) ? T_LONG : T_REP);
            push(vecs[v].key, T_REL);
            key_raw[vecs[v].key] = 1'b0;
            repeat (vecs[v].hold) tick();
            key_raw[vecs[v].key] = 1'b1;
            repeat (12) tick();
            check($sformatf("vec%0d_press_cnt", v), cnt_press[vecs[v].key] - p0, 1);
            check($sformatf("vec%0d_release_cnt", v), cnt_rel[vecs[v].key] - r0, 1);
            check($sformatf("vec%0d_long_cnt", v), cnt_long[vecs[v].key] - l0, vecs[v].n_long);
            check($sformatf("vec%0d_level", v), 32'(key_level), 0);
            wait_drain();
        end

        // Keys 0 and 2 pressed in the same cycle.
        push(0, T_PRESS);
        push(2, T_PRESS);
        push(0, T_REL);
        push(2, T_REL);
        key_raw = 3'b010;
        repeat (6) tick();
        check("dual_press_pulse", 32'(press_pulse), 32'h5);
        tick();
        check("dual_press_done", 32'(press_pulse), 0);
        tick();
        check("dual_first_valid", 32'(evt_valid), 1);
        check("dual_first_key", 32'(evt_key), 0);
        tick();
        check("dual_second_valid", 32'(evt_valid), 1);
        check("dual_second_key", 32'(evt_key), 2);
        check("dual_second_type", 32'(evt_type), 32'(T_PRESS));
        repeat (6) tick();
        key_raw = 3'b111;
        repeat (12) tick();
        wait_drain();

        // Back-pressure: fill the queue, leave one pending, then collide on it.
        evt_ready = 1'b0;
        push(0, T_PRESS);
        push(0, T_REL);
        push(1, T_PRESS);
        push(1, T_REL);
        push(2, T_PRESS);
        push(2, T_REL);
        key_raw = 3'b110;
        repeat (10) tick();
        key_raw = 3'b111;
        repeat (12) tick();
        key_raw = 3'b101;
        repeat (10) tick();
        key_raw = 3'b111;
        repeat (12) tick();
        key_raw = 3'b011;
        repeat (12) tick();
        check("full_valid", 32'(evt_valid), 1);
        check("full_head_key", 32'(evt_key), 0);
        check("full_head_type", 32'(evt_type), 32'(T_PRESS));
        check("full_no_overflow", 32'(evt_overflow), 0);
        key_raw = 3'b111;
        repeat (12) tick();
        check("release_pending_no_overflow", 32'(evt_overflow), 0);
        key_raw = 3'b011;
        repeat (12) tick();
        check("overflow_set", 32'(evt_overflow), 1);
        check("stalled_head_key", 32'(evt_key), 0);
        evt_ready = 1'b1;
        wait_drain();
        check("overflow_sticky", 32'(evt_overflow), 1);
        push(2, T_REL);
        key_raw = 3'b111;
        repeat (12) tick();
        wait_drain();
        check("overflow_still_sticky", 32'(evt_overflow), 1);

        // Reset in the middle of a hold on key 1 with an event queued.
        evt_ready = 1'b0;
        key_raw   = 3'b101;
        repeat (12) tick();
        check("midhold_level", 32'(key_level), 32'h2);
        check("midhold_valid", 32'(evt_valid), 1);
        sys_rst = 1'b1;
        key_raw = 3'b111;
        tick();
        check("midrst_level", 32'(key_level), 0);
        check("midrst_valid", 32'(evt_valid), 0);
        check("midrst_overflow", 32'(evt_overflow), 0);
        check("midrst_long", 32'(long_pulse), 0);
        sys_rst   = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_idle", 32'(evt_valid), 0);
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
